div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the execute stage of the MIPS pipeline, serving DIV and DIVU. It latches operands when a divide enters EX and runs a one-bit-per-cycle restoring division. It produces the 64-bit {remainder, quotient} pair for the HI/LO write path. It drives `div_stall` into the hazard unit, holding the whole pipeline until the result is ready, and it aborts cleanly when the instruction is flushed by an exception.

---
 rtl/div_unit.sv | 80 ++++++++
 tb/tb_div_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for DIV/DIVU with pipeline stall,
// external-stall result hold and exception annul.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signed_div,
  input  logic        start,
  input  logic        annul,
  input  logic        stall_ext,
  output logic [63:0] result,
  output logic        ready,
  output logic        div_stall
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q;
  logic [31:0] rem_q, quo_q, dvs_q, rem_d, quo_d, a_mag, b_mag;
  logic [32:0] shl, diff;
  logic [5:0]  cnt_q;
  logic        neg_quo_q, neg_rem_q;
  // MIN stays 0x80000000 after negation and is then treated as an unsigned magnitude
  always_comb begin
    a_mag = (signed_div & a[31]) ? -a : a;
    b_mag = (signed_div & b[31]) ? -b : b;
    shl   = {rem_q, quo_q[31]};
    diff  = shl - {1'b0, dvs_q};
    rem_d = diff[32] ? shl[31:0] : diff[31:0];
    quo_d = {quo_q[30:0], ~diff[32]};
  end
  assign div_stall = ~annul & ((state_q == IDLE & start) | state_q == BUSY);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result    <= '0;
      ready     <= 1'b0;
    end else if (annul) begin
      state_q <= IDLE;
      ready   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          if (b == 32'd0) begin
            state_q <= DONE;
            ready   <= 1'b1;
            result  <= {a, 32'hFFFF_FFFF};
          end else begin
            state_q   <= BUSY;
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            cnt_q     <= '0;
            neg_quo_q <= signed_div & (a[31] ^ b[31]);
            neg_rem_q <= signed_div & a[31];
          end
        end
        BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= DONE;
            ready   <= 1'b1;
            result  <= {neg_rem_q ? -rem_d : rem_d, neg_quo_q ? -quo_d : quo_d};
          end
        end
        DONE: if (!stall_ext) begin
          state_q <= IDLE;
          ready   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed scoreboard bench for div_unit covering latency, signs,
// divide-by-zero, annul, external stall hold and asynchronous reset.
module tb_div_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        signed_div = 1'b0, start = 1'b0, annul = 1'b0, stall_ext = 1'b0;
  logic [63:0] result;
  logic        ready, div_stall;
  int          checks = 0, failures = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  div_unit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .signed_div(signed_div), .start(start),
    .annul(annul), .stall_ext(stall_ext), .result(result), .ready(ready), .div_stall(div_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic sd);
    longint sx, sy;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (!sd) return {x % y, x / y};
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    return {32'(sx % sy), 32'(sx / sy)};
  endfunction

  // Start a divide, check stall/ready every cycle, then hold the result for `hold` extra cycles
  task automatic do_div(input logic [31:0] ta, input logic [31:0] tb, input logic sd, input int hold);
    int lat;
    logic [63:0] exp;
    lat = (tb == 32'd0) ? 1 : 33;
    @(negedge clk);
    a = ta; b = tb; signed_div = sd; start = 1'b1;
    sb_q.push_back(model(ta, tb, sd));
    #1 chk("stall_start", div_stall, 1);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      #1 chk("stall_busy", div_stall, 1);
      chk("ready_busy", ready, 0);
    end
    @(negedge clk);
    start = 1'b0; stall_ext = (hold > 0);
    #1 chk("ready_done", ready, 1);
    chk("stall_done", div_stall, 0);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    chk("result", result, exp);
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      stall_ext = (i < hold);
      #1 chk("ready_hold", ready, 1);
      chk("result_hold", result, exp);
    end
  endtask

  initial begin
    #1 chk("rst_result", result, 0);
    chk("rst_ready", ready, 0);
    chk("rst_stall_idle", div_stall, 0);
    start = 1'b1;
    #1 chk("rst_stall_start", div_stall, 1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_div(32'd100, 32'd7, 1'b0, 0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_div(32'h1234_5678, 32'd0, 1'b0, 0);
    do_div(32'hFFFF_FFFB, 32'd0, 1'b1, 0);
    do_div(32'hFFFF_FFFF, 32'd3, 1'b0, 0);
    do_div(32'hFFFF_FFFF, 32'd3, 1'b1, 0);
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    do_div(32'h8000_0000, 32'd7, 1'b0, 0);

    // External stall keeps DONE alive; IDLE follows the first unstalled DONE cycle
    do_div(32'd1000, 32'd33, 1'b0, 2);
    @(negedge clk);
    #1 chk("ready_after_hold", ready, 0);

    // Annul during BUSY abandons the divide
    @(negedge clk);
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      #1 chk("ready_pre_annul", ready, 0);
    end
    @(negedge clk);
    annul = 1'b1;
    #1 chk("stall_annul", div_stall, 0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    #1 chk("ready_post_annul", ready, 0);
    chk("stall_post_annul", div_stall, 0);
    do_div(32'd100, 32'd7, 1'b0, 0);

    // Annul together with start in IDLE must not launch anything
    @(negedge clk);
    a = 32'd5; b = 32'd1; start = 1'b1; annul = 1'b1;
    #1 chk("stall_annul_start", div_stall, 0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    #1 chk("stall_no_launch", div_stall, 0);
    chk("ready_no_launch", ready, 0);

    // Asynchronous reset mid-BUSY clears result immediately
    @(negedge clk);
    a = 32'd500; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_mid_ready", ready, 0);
    chk("rst_mid_result", result, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1 chk("rst_mid_idle", div_stall, 0);
    do_div(32'd1000, 32'd10, 1'b0, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
